biquad8_pole_coeff_loader: RTL and testbench

- Host-side writer for the coefficient port of the 8-sample biquad pole IIR.
- Holds four shadow coefficients: A, B (the y0 row) and C, D (the y1 row).
- On a load request it replays them onto the filter's shift-chain coefficient port in the required order, then issues the update strobe so all four take effect on the same cycle.
- Sits between the register bus and the IIR core.

---
 rtl/biquad8_pole_coeff_loader_pkg.sv | 24 ++
 rtl/biquad8_pole_coeff_loader.sv | 144 ++++++++++++++
 tb/tb_biquad8_pole_coeff_loader.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/biquad8_pole_coeff_loader_pkg.sv
// Shared constants for the biquad pole coefficient loader: FSM encoding,
// shadow register indices and the sequence-to-shadow replay order.
package biquad8_pole_coeff_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [1:0] COEF_A = 2'd0;
  localparam logic [1:0] COEF_B = 2'd1;
  localparam logic [1:0] COEF_C = 2'd2;
  localparam logic [1:0] COEF_D = 2'd3;

  localparam int SEQ_LEN = 4;

  // The filter chain fills from the far end, so the last stage (D) goes first.
  function automatic logic [1:0] seq_to_shadow(input logic [1:0] idx);
    return COEF_D - idx;
  endfunction

endpackage

// File: rtl/biquad8_pole_coeff_loader.sv
// Shadow coefficient register file plus a replay FSM that shifts the four
// coefficients into the IIR chain and then fires a single update strobe.
module biquad8_pole_coeff_loader
  import biquad8_pole_coeff_loader_pkg::*;
#(
  parameter int COEFF_BITS = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [1:0]            wr_adr_i,
  input  logic [COEFF_BITS-1:0] wr_dat_i,
  input  logic [1:0]            rd_adr_i,
  output logic [COEFF_BITS-1:0] rd_dat_o,
  input  logic                  load_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [1:0]            coeff_adr_o,
  output logic [COEFF_BITS-1:0] coeff_dat_o,
  output logic                  coeff_wr_o,
  output logic                  coeff_update_o
);

  // Handshake: load_i is a one-cycle request with no ready; a request seen
  // while a sequence is running is remembered in pending_q and coalesced.

  state_e                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic                  pending_q, pending_d;
  logic [COEFF_BITS-1:0] shadow_q [SEQ_LEN];
  logic [COEFF_BITS-1:0] shadow_d [SEQ_LEN];
  logic [COEFF_BITS-1:0] snap_q [SEQ_LEN];
  logic [COEFF_BITS-1:0] snap_d [SEQ_LEN];
  logic [COEFF_BITS-1:0] rd_dat_q, rd_dat_d;
  logic [COEFF_BITS-1:0] coeff_dat_q, coeff_dat_d;
  logic [1:0]            coeff_adr_q, coeff_adr_d;
  logic                  coeff_wr_q, coeff_wr_d;
  logic                  coeff_update_q, coeff_update_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  always_comb begin
    shadow_d = shadow_q;
    if (wr_en_i) shadow_d[wr_adr_i] = wr_dat_i;

    state_d        = state_q;
    idx_d          = idx_q;
    pending_d      = pending_q;
    snap_d         = snap_q;
    rd_dat_d       = shadow_q[rd_adr_i];
    coeff_dat_d    = coeff_dat_q;
    coeff_adr_d    = coeff_adr_q;
    coeff_wr_d     = 1'b0;
    coeff_update_d = 1'b0;
    busy_d         = 1'b0;
    done_d         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (load_i) begin
          // shadow_d carries any same-cycle write, so the snapshot includes it.
          snap_d  = shadow_d;
          idx_d   = 2'd0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        coeff_wr_d  = 1'b1;
        coeff_adr_d = idx_q;
        coeff_dat_d = snap_q[seq_to_shadow(idx_q)];
        busy_d      = 1'b1;
        if (load_i) pending_d = 1'b1;
        if (idx_q == 2'(SEQ_LEN - 1)) begin
          state_d = ST_UPDATE;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      ST_UPDATE: begin
        // Kept a cycle apart from the last write so the filter sees settled stages.
        coeff_update_d = 1'b1;
        busy_d         = 1'b1;
        if (load_i) pending_d = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d = 1'b1;
        if (pending_q || load_i) begin
          pending_d = 1'b0;
          busy_d    = 1'b1;
          snap_d    = shadow_d;
          idx_d     = 2'd0;
          state_d   = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      idx_q          <= 2'd0;
      pending_q      <= 1'b0;
      rd_dat_q       <= '0;
      coeff_dat_q    <= '0;
      coeff_adr_q    <= 2'd0;
      coeff_wr_q     <= 1'b0;
      coeff_update_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      for (int i = 0; i < SEQ_LEN; i++) begin
        shadow_q[i] <= '0;
        snap_q[i]   <= '0;
      end
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      pending_q      <= pending_d;
      rd_dat_q       <= rd_dat_d;
      coeff_dat_q    <= coeff_dat_d;
      coeff_adr_q    <= coeff_adr_d;
      coeff_wr_q     <= coeff_wr_d;
      coeff_update_q <= coeff_update_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      for (int i = 0; i < SEQ_LEN; i++) begin
        shadow_q[i] <= shadow_d[i];
        snap_q[i]   <= snap_d[i];
      end
    end
  end

  assign rd_dat_o       = rd_dat_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign coeff_adr_o    = coeff_adr_q;
  assign coeff_dat_o    = coeff_dat_q;
  assign coeff_wr_o     = coeff_wr_q;
  assign coeff_update_o = coeff_update_q;

endmodule

// File: tb/tb_biquad8_pole_coeff_loader.sv
// Directed bench for the coefficient loader: vector tables for the replay
// sequence and readback, hand-written load/reset corner sequences.
module tb_biquad8_pole_coeff_loader;

  localparam int CB = 18;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en_i = 1'b0;
  logic [1:0]    wr_adr_i = 2'd0;
  logic [CB-1:0] wr_dat_i = '0;
  logic [1:0]    rd_adr_i = 2'd0;
  logic [CB-1:0] rd_dat_o;
  logic          load_i = 1'b0;
  logic          busy_o;
  logic          done_o;
  logic [1:0]    coeff_adr_o;
  logic [CB-1:0] coeff_dat_o;
  logic          coeff_wr_o;
  logic          coeff_update_o;

  biquad8_pole_coeff_loader #(.COEFF_BITS(CB)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_en_i        (wr_en_i),
    .wr_adr_i       (wr_adr_i),
    .wr_dat_i       (wr_dat_i),
    .rd_adr_i       (rd_adr_i),
    .rd_dat_o       (rd_dat_o),
    .load_i         (load_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .coeff_adr_o    (coeff_adr_o),
    .coeff_dat_o    (coeff_dat_o),
    .coeff_wr_o     (coeff_wr_o),
    .coeff_update_o (coeff_update_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- filter chain model ----------------
  logic [CB-1:0] stage [4];
  logic [CB-1:0] active [4];
  int            upd_cnt = 0;

  initial begin
    for (int i = 0; i < 4; i++) begin
      stage[i]  = '0;
      active[i] = '0;
    end
  end

  always @(posedge clk) begin
    if (coeff_update_o) begin
      upd_cnt = upd_cnt + 1;
      for (int i = 0; i < 4; i++) active[i] = stage[i];
    end
    if (coeff_wr_o) begin
      for (int j = 3; j > 0; j--) if (j <= int'(coeff_adr_o)) stage[j] = stage[j-1];
      stage[0] = coeff_dat_o;
    end
  end

  // Update and write strobes must never coincide.
  always @(negedge clk) begin
    if (rst_n) begin
      checks = checks + 1;
      if (coeff_wr_o && coeff_update_o) begin
        failures = failures + 1;
        $display("FAIL wr_upd_overlap actual=1 required=0 at %0t", $time);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic wr_shadow(input logic [1:0] adr, input logic [CB-1:0] dat);
    wr_en_i  = 1'b1;
    wr_adr_i = adr;
    wr_dat_i = dat;
    step();
    wr_en_i  = 1'b0;
  endtask

  task automatic pulse_load();
    load_i = 1'b1;
    step();
    load_i = 1'b0;
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic          wr;
    logic          upd;
    logic          done;
    logic          busy;
    logic [1:0]    adr;
    logic [CB-1:0] dat;
  } cyc_t;

  typedef struct {
    logic [1:0]    adr;
    logic [CB-1:0] dat;
  } wv_t;

  cyc_t seq_tab [7];
  wv_t  wr_tab [4];

  task automatic run_seq_table(input string tag);
    pulse_load();
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("%s_wr_T%0d", tag, i + 1), 32'(coeff_wr_o), 32'(seq_tab[i].wr));
      chk($sformatf("%s_upd_T%0d", tag, i + 1), 32'(coeff_update_o), 32'(seq_tab[i].upd));
      chk($sformatf("%s_done_T%0d", tag, i + 1), 32'(done_o), 32'(seq_tab[i].done));
      chk($sformatf("%s_busy_T%0d", tag, i + 1), 32'(busy_o), 32'(seq_tab[i].busy));
      chk($sformatf("%s_adr_T%0d", tag, i + 1), 32'(coeff_adr_o), 32'(seq_tab[i].adr));
      chk($sformatf("%s_dat_T%0d", tag, i + 1), 32'(coeff_dat_o), 32'(seq_tab[i].dat));
    end
    for (int s = 0; s < 4; s++)
      chk($sformatf("%s_filter_stage%0d", tag, s), 32'(active[s]), 32'(wr_tab[s].dat));
  endtask

  // ---------------- main test ----------------
  int       upd_before;
  logic     exp_busy, exp_done, exp_wr, exp_upd;
  logic [31:0] exp_q[$];
  int       waited;

  initial begin
    seq_tab[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 18'h00004};
    seq_tab[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 18'h00003};
    seq_tab[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 18'h00002};
    seq_tab[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 18'h00001};
    seq_tab[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 18'h00001};
    seq_tab[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 18'h00001};
    seq_tab[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 18'h00001};
    wr_tab[0] = '{2'd0, 18'h00001};
    wr_tab[1] = '{2'd1, 18'h00002};
    wr_tab[2] = '{2'd2, 18'h00003};
    wr_tab[3] = '{2'd3, 18'h00004};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_dat", 32'(rd_dat_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    chk("rst_wr", 32'(coeff_wr_o), 32'h0);
    chk("rst_upd", 32'(coeff_update_o), 32'h0);
    chk("rst_adr", 32'(coeff_adr_o), 32'h0);
    chk("rst_dat", 32'(coeff_dat_o), 32'h0);
    rst_n = 1'b1;
    step();

    // Basic sequence from table
    for (int i = 0; i < 4; i++) wr_shadow(wr_tab[i].adr, wr_tab[i].dat);
    run_seq_table("seq1");

    // Same-cycle write of D is bypassed into the snapshot
    wr_en_i = 1'b1; wr_adr_i = 2'd3; wr_dat_i = 18'h3FFFF; load_i = 1'b1;
    step();
    wr_en_i = 1'b0; load_i = 1'b0;
    step();
    chk("byp_wr", 32'(coeff_wr_o), 32'h1);
    chk("byp_adr", 32'(coeff_adr_o), 32'h0);
    chk("byp_dat", 32'(coeff_dat_o), 32'h3FFFF);
    repeat (6) step();
    chk("byp_idle_busy", 32'(busy_o), 32'h0);

    // Coalesced re-run: load at T and T+2, B changed at T+3
    load_i = 1'b1;
    step();
    load_i = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      load_i = (k == 2);
      wr_en_i = (k == 3); wr_adr_i = 2'd1; wr_dat_i = 18'h00055;
      step();
      load_i = 1'b0; wr_en_i = 1'b0;
      exp_busy = (k <= 11);
      exp_done = (k == 6) || (k == 12);
      exp_wr   = (k >= 1 && k <= 4) || (k >= 7 && k <= 10);
      exp_upd  = (k == 5) || (k == 11);
      chk($sformatf("coal_busy_T%0d", k), 32'(busy_o), 32'(exp_busy));
      chk($sformatf("coal_done_T%0d", k), 32'(done_o), 32'(exp_done));
      chk($sformatf("coal_wr_T%0d", k), 32'(coeff_wr_o), 32'(exp_wr));
      chk($sformatf("coal_upd_T%0d", k), 32'(coeff_update_o), 32'(exp_upd));
      if (k == 3) chk("coal_first_B", 32'(coeff_dat_o), 32'h00002);
      if (k == 7) chk("coal_second_D", 32'(coeff_dat_o), 32'h3FFFF);
      if (k == 9) chk("coal_second_B", 32'(coeff_dat_o), 32'h00055);
    end
    chk("coal_filter_B", 32'(active[1]), 32'h00055);

    // Reset asserted mid-sequence
    upd_before = upd_cnt;
    pulse_load();
    step();
    step();
    chk("mid_wr_before_rst", 32'(coeff_wr_o), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr", 32'(coeff_wr_o), 32'h0);
    chk("mid_rst_upd", 32'(coeff_update_o), 32'h0);
    chk("mid_rst_busy", 32'(busy_o), 32'h0);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_rst_no_update", 32'(upd_cnt), 32'(upd_before));
    chk("mid_rst_filter_D", 32'(active[3]), 32'h3FFFF);
    rst_n = 1'b1;
    step();

    // Clean sequence after reset (shadows were cleared, so rewrite them)
    for (int i = 0; i < 4; i++) wr_shadow(wr_tab[i].adr, wr_tab[i].dat);
    run_seq_table("seq2");

    // Readback scoreboard
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(wr_tab[i].dat));
    for (int i = 0; i < 4; i++) begin
      rd_adr_i = 2'(i);
      step();
      chk($sformatf("rdback_%0d", i), 32'(rd_dat_o), exp_q.pop_front());
    end

    // Random traffic; overlap monitor runs every cycle
    for (int c = 0; c < 300; c++) begin
      load_i   = ($urandom_range(0, 9) == 0);
      wr_en_i  = ($urandom_range(0, 3) == 0);
      wr_adr_i = 2'($urandom_range(0, 3));
      wr_dat_i = 18'($urandom_range(0, 18'h3FFFF));
      rd_adr_i = 2'($urandom_range(0, 3));
      step();
    end
    load_i = 1'b0; wr_en_i = 1'b0;
    waited = 0;
    while ((busy_o || coeff_wr_o || coeff_update_o) && waited < 50) begin
      step();
      waited++;
    end
    chk("rand_drain_timeout", 32'(waited < 50), 32'h1);
    repeat (3) step();
    chk("rand_final_idle", 32'(busy_o), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
